// File: rtl/countdown_timer.sv
// Four-digit BCD millisecond countdown timer with seven-segment outputs.
// A prescaler divides clk down to 1 ms ticks; a small FSM controls run/pause/expiry.
module countdown_timer #(
    parameter int CLK_PER_MS = 50000
) (
    input  logic        clk,
    input  logic        sync_reset,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    output logic [7:0]  hex0,
    output logic [7:0]  hex1,
    output logic [7:0]  hex2,
    output logic [7:0]  hex3,
    output logic        done,
    output logic        alarm
);

    localparam int PW = $clog2(CLK_PER_MS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     digits_q, digits_d;
    logic            done_q, done_d;
    logic            alarm_q, alarm_d;
    logic [7:0]      hex0_q, hex1_q, hex2_q, hex3_q;
    logic            tick_s;
    logic            expire_s;

    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Ripple-borrow decrement; a zero digit wraps to 9 and passes the borrow upward.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign tick_s   = (state_q == S_RUN) && (presc_q == PRESC_MAX);
    // A stop on the same cycle discards the tick, so it cannot expire either.
    assign expire_s = tick_s && (digits_q == 16'h0001) && !stop;

    // State register plus all datapath/output registers.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            digits_q <= 16'h0000;
            done_q   <= 1'b0;
            alarm_q  <= 1'b0;
            hex0_q   <= 8'hC0;
            hex1_q   <= 8'hC0;
            hex2_q   <= 8'hC0;
            hex3_q   <= 8'hC0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            digits_q <= digits_d;
            done_q   <= done_d;
            alarm_q  <= alarm_d;
            hex0_q   <= seg7(digits_q[3:0]);
            hex1_q   <= seg7(digits_q[7:4]);
            hex2_q   <= seg7(digits_q[11:8]);
            hex3_q   <= seg7(digits_q[15:12]);
        end
    end

    // Next-state logic; in RUN the priority is stop, then expiry, then pause.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_IDLE;
                end else if (start && (digits_q != 16'h0000)) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (expire_s) begin
                    state_d = S_EXPIRED;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (pause) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_EXPIRED: begin
                if (start || stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXPIRED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Prescaler, digit and flag updates for the coming cycle.
    always_comb begin
        presc_d  = presc_q;
        digits_d = digits_q;
        done_d   = 1'b0;
        alarm_d  = alarm_q;
        case (state_q)
            S_IDLE: begin
                alarm_d = 1'b0;
                if (load) begin
                    digits_d = clamp_bcd(preset);
                end else if (start && (digits_q != 16'h0000)) begin
                    presc_d = '0;
                end else begin
                    presc_d = presc_q;
                end
            end
            S_RUN: begin
                if (stop) begin
                    digits_d = 16'h0000;
                    presc_d  = '0;
                end else begin
                    if (tick_s) begin
                        presc_d  = '0;
                        digits_d = bcd_dec(digits_q);
                    end else begin
                        presc_d  = presc_q + PW'(1);
                    end
                    if (expire_s) begin
                        done_d  = 1'b1;
                        alarm_d = 1'b1;
                    end else begin
                        alarm_d = alarm_q;
                    end
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    digits_d = 16'h0000;
                    presc_d  = '0;
                end else begin
                    digits_d = digits_q;
                end
            end
            S_EXPIRED: begin
                digits_d = 16'h0000;
                if (start || stop) begin
                    alarm_d = 1'b0;
                end else begin
                    alarm_d = 1'b1;
                end
            end
            default: begin
                presc_d  = '0;
                digits_d = 16'h0000;
            end
        endcase
    end

    assign hex0  = hex0_q;
    assign hex1  = hex1_q;
    assign hex2  = hex2_q;
    assign hex3  = hex3_q;
    assign done  = done_q;
    assign alarm = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios then random control pulses,
// every cycle compared against a decimal-arithmetic reference model.
module tb_countdown_timer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        sync_reset, load, start, pause, stop;
    logic [15:0] preset;
    logic [7:0]  hex0, hex1, hex2, hex3;
    logic        done, alarm;

    always #5 clk = ~clk;

    countdown_timer #(.CLK_PER_MS(N)) dut (
        .clk(clk), .sync_reset(sync_reset), .load(load), .preset(preset),
        .start(start), .pause(pause), .stop(stop),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .done(done), .alarm(alarm)
    );

    // Reference model: mode 0 idle, 1 run, 2 pause, 3 expired; value as a plain integer.
    int   m_mode = 0, m_val = 0, m_cnt = 0, m_hexval = 0;
    logic m_done = 1'b0, m_alarm = 1'b0;
    int   checks = 0, passed = 0, done_seen = 0;

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int preset_value(input logic [15:0] p);
        int v = 0;
        int d;
        for (int i = 3; i >= 0; i--) begin
            d = int'(p[4*i +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_edge(input logic ld, st, pa, sp, rs, input logic [15:0] pr);
        bit tick;
        m_hexval = rs ? 0 : m_val;
        m_done   = 1'b0;
        if (rs) begin
            m_mode = 0; m_val = 0; m_cnt = 0; m_alarm = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    if (ld) m_val = preset_value(pr);
                    else if (st && m_val != 0) begin m_mode = 1; m_cnt = 0; end
                end
                1: begin
                    tick  = (m_cnt == N - 1);
                    m_cnt = (m_cnt + 1) % N;
                    if (sp) begin
                        m_mode = 0; m_val = 0;
                    end else begin
                        if (tick) m_val = m_val - 1;
                        if (tick && m_val == 0) begin
                            m_mode = 3; m_done = 1'b1; m_alarm = 1'b1;
                        end else if (pa) m_mode = 2;
                    end
                end
                2: begin
                    if (sp) begin m_mode = 0; m_val = 0; end
                    else if (pa) m_mode = 1;
                end
                default: begin
                    if (st || sp) begin m_mode = 0; m_alarm = 1'b0; end
                end
            endcase
        end
    endtask

    task automatic step(input logic ld, st, pa, sp, rs, input logic [15:0] pr);
        load = ld; start = st; pause = pa; stop = sp; sync_reset = rs; preset = pr;
        @(posedge clk);
        model_edge(ld, st, pa, sp, rs, pr);
        #1;
        if (done === 1'b1) done_seen++;
        check1("done", done, m_done);
        check1("alarm", alarm, m_alarm);
        check8("hex0", hex0, seg_of(m_hexval % 10));
        check8("hex1", hex1, seg_of((m_hexval / 10) % 10));
        check8("hex2", hex2, seg_of((m_hexval / 100) % 10));
        check8("hex3", hex3, seg_of((m_hexval / 1000) % 10));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        load = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        sync_reset = 1'b1; preset = 16'h0000;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        idle(1);
        check8("reset_hex3", hex3, 8'hC0);

        // Count 3 down to expiry
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003);
        done_seen = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(14);
        check_int("done_pulses", done_seen, 1);
        check1("expired_alarm", alarm, 1'b1);
        check8("expired_hex0", hex0, 8'hC0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(1);
        check1("ack_alarm", alarm, 1'b0);

        // Borrow chain 1000 -> 0999
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(5);
        check8("borrow_hex3", hex3, 8'hC0);
        check8("borrow_hex2", hex2, 8'h90);
        check8("borrow_hex1", hex1, 8'h90);
        check8("borrow_hex0", hex0, 8'h90);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        idle(1);

        // Pause and resume from 0050
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0050);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        idle(20);
        check8("pause_hex1", hex1, 8'h99);
        check8("pause_hex0", hex0, 8'h90);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        idle(1);
        check8("resume_hex0_hold", hex0, 8'h90);
        idle(2);
        check8("resume_hex0_tick", hex0, 8'h80);

        // Stop and pause together in RUN
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        idle(1);
        check8("stop_hex1", hex1, 8'hC0);
        check1("stop_alarm", alarm, 1'b0);

        // Clamp FFFF -> 9999, then start from 0000 after reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        idle(1);
        check8("clamp_hex3", hex3, 8'h90);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        done_seen = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(10);
        check_int("zero_start_done", done_seen, 0);

        // Reset in EXPIRED, then count normally
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(6);
        check1("exp_alarm_pre", alarm, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        check1("exp_reset_alarm", alarm, 1'b0);
        check8("exp_reset_hex2", hex2, 8'hC0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        idle(10);
        check1("recount_alarm", alarm, 1'b1);

        // Random control pulses
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] pr;
            pr = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                             : {8'h00, 4'($urandom_range(0, 2)), 4'($urandom)};
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 299) == 0), pr);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
